mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the instruction-fetch requester (I) and the load/store requester (D).
- Target is the multicycle/pipelined core variants that replace the split ramI/ramD pair with one unified RAM.
- Performs req/gnt arbitration, drives the memory command, tracks read latency and returns read data to the issuing port with a valid pulse.
- One transaction is outstanding at a time.

Parameters:
- ADDR_W, 10, word-address width (memory address bits [11:2] of the byte address).
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from command cycle to iMemRData valid; legal range 1..3.

Ports:
- iCLK  in  1  single clock; all state updates on the rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iIReq  in  1  instruction read request; held with a stable address until oIGnt.
- iIAddr  in  ADDR_W  instruction word address.
- oIGnt  out  1  grant to I; command issued this cycle.
- oIValid  out  1  one-cycle pulse; oIData is valid.
- oIData  out  DATA_W  returned instruction word.
- iDReq  in  1  data request; held with stable iDWe, address and data until oDGnt.
- iDWe  in  1  1 = write, 0 = read.
- iDAddr  in  ADDR_W  data word address.
- iDWData  in  DATA_W  write data.
- oDGnt  out  1  grant to D.
- oDValid  out  1  one-cycle pulse; oDData is valid (reads only).
- oDData  out  DATA_W  returned load data.
- oMemAddr  out  ADDR_W  memory address.
- oMemWData  out  DATA_W  memory write data.
- oMemWe  out  1  memory write enable.
- oMemRe  out  1  memory read enable.
- iMemRData  in  DATA_W  memory read data.
- oBusy  out  1  1 while a read is in flight.

Behaviour:
- Reset (iRST=0, asynchronous):
  - state=IDLE, lastGnt=I, latency counter=0, tag=I.
  - oIValid=oDValid=0, oIData=oDData=0, oMemAddr=0, oMemWData=0, oBusy=0.
  - Grants and oMemWe/oMemRe are forced to 0 while in reset.
- States:
  - IDLE: arbitration enabled.
  - RD_WAIT: read in flight, no grants.
  - RD_RET: capture data.
- Grants (IDLE only): oXGnt, oMemWe/oMemRe and the oMemAddr/oMemWData mux are combinational from the requests in the same cycle. A grant is exactly one cycle, and at most one grant is asserted per cycle.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the port not equal to lastGnt wins.
  - After reset, lastGnt=I, so D wins the first contention.
  - lastGnt updates on every grant.
  - Worst-case wait for either port is one transaction.
- Write (D, iDWe=1):
  - oMemWe=1 in the grant cycle; no valid pulse.
  - State stays IDLE; a new grant is possible next cycle.
- Read (I, or D with iDWe=0):
  - oMemRe=1 in grant cycle t.
  - tag <= winner; counter <= MEM_LAT-1; go to RD_WAIT when MEM_LAT>1, otherwise go directly to RD_RET.
  - RD_WAIT decrements the counter and moves to RD_RET when the counter reaches 0.
  - In RD_RET (cycle t+MEM_LAT), iMemRData is registered into oXData of the tagged port.
  - oXValid=1 in cycle t+MEM_LAT+1; state returns to IDLE at that edge.
  - Arbitration resumes in cycle t+MEM_LAT+1 (the valid cycle). Throughput is one read per MEM_LAT+1 cycles.
- Data outputs: oXData holds its last value until the next read for that port. The non-tagged port's data and valid are untouched.
- oMemAddr/oMemWData: hold the value of the last issued command in non-grant cycles.
- oBusy: 1 from the cycle after a read grant through RD_RET.
- Requests arriving during RD_WAIT/RD_RET wait; they are never dropped.
- Requests deasserted before grant are a requester protocol violation; the arbiter simply does not grant them.
- Reset asserted mid-read: the read is abandoned, no valid pulse follows, and state is IDLE after release.
- MEM_LAT outside 1..3 is a configuration error (simulation assertion).

Test Plan:
- Reset, then iIReq=1, iIAddr=0x004, memory returns 0x00500093 with MEM_LAT=1:
  - oIGnt=1 and oMemRe=1 in cycle 0.
  - oIValid=1 with oIData=0x00500093 in cycle 2.
  - oDValid stays 0.
- Both requests in the same cycle after reset (D read 0x010, I read 0x008):
  - D granted first, I granted in D's valid cycle.
  - Alternation continues under permanent contention (grant order D, I, D, I).
- D write 0x3FF <= 0xDEADBEEF followed immediately by D read 0x3FF:
  - Write grant with oMemWe=1 and no valid pulse.
  - Read granted the next cycle; oDData=0xDEADBEEF.
- MEM_LAT=3, I read: oIGnt at t, oBusy=1 during t+1..t+3, oIValid at t+4. An iDReq raised at t+1 is granted at t+4.
- iRST pulled low during RD_WAIT:
  - All outputs go to 0 immediately.
  - No oIValid/oDValid appears after release.
  - The next request is granted normally with D priority on contention.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch (I) and load/store (D).
// One transaction is outstanding at a time. Read data returns to the issuing port with a one-cycle valid pulse.
module mem_port_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iIReq,
   input  logic [ADDR_W-1:0] iIAddr,
   output logic              oIGnt,
   output logic              oIValid,
   output logic [DATA_W-1:0] oIData,
   input  logic              iDReq,
   input  logic              iDWe,
   input  logic [ADDR_W-1:0] iDAddr,
   input  logic [DATA_W-1:0] iDWData,
   output logic              oDGnt,
   output logic              oDValid,
   output logic [DATA_W-1:0] oDData,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemWData,
   output logic              oMemWe,
   output logic              oMemRe,
   input  logic [DATA_W-1:0] iMemRData,
   output logic              oBusy
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RET} state_t;
   typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

   localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

   state_t            state, state_nxt;
   logic [1:0]        cnt, cnt_nxt;
   port_t             last_gnt, tag;
   logic              i_win, d_win, rd_gnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      i_win     = 1'b0;
      d_win     = 1'b0;
      case (state)
         IDLE: begin
            // Grants are gated by reset so the RAM sees no command while iRST is low.
            if (iRST) begin
               if (iIReq && iDReq) begin
                  if (last_gnt == PORT_I) d_win = 1'b1;
                  else                    i_win = 1'b1;
               end else begin
                  i_win = iIReq;
                  d_win = iDReq;
               end
            end
            if (i_win || (d_win && !iDWe)) begin
               cnt_nxt = LAT_INIT;
               if (MEM_LAT > 1) state_nxt = RD_WAIT;
               else             state_nxt = RD_RET;
            end
         end
         RD_WAIT: begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1) state_nxt = RD_RET;
         end
         RD_RET:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_gnt    = i_win | (d_win & ~iDWe);
   assign oIGnt     = i_win;
   assign oDGnt     = d_win;
   assign oMemRe    = rd_gnt;
   assign oMemWe    = d_win & iDWe;
   assign oMemAddr  = i_win ? iIAddr : (d_win ? iDAddr : addr_q);
   assign oMemWData = d_win ? iDWData : wdata_q;
   assign oBusy     = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         last_gnt <= PORT_I;
         tag      <= PORT_I;
         addr_q   <= '0;
         wdata_q  <= '0;
         oIValid  <= 1'b0;
         oDValid  <= 1'b0;
         oIData   <= '0;
         oDData   <= '0;
      end else begin
         oIValid <= 1'b0;
         oDValid <= 1'b0;
         if (i_win) begin
            last_gnt <= PORT_I;
            addr_q   <= iIAddr;
         end else if (d_win) begin
            last_gnt <= PORT_D;
            addr_q   <= iDAddr;
            wdata_q  <= iDWData;
         end
         if (rd_gnt) begin
            if (i_win) tag <= PORT_I;
            else       tag <= PORT_D;
         end
         // The RAM output is valid in RD_RET; steer it to whichever port issued the read.
         if (state == RD_RET) begin
            if (tag == PORT_I) begin
               oIData  <= iMemRData;
               oIValid <= 1'b1;
            end else begin
               oDData  <= iMemRData;
               oDValid <= 1'b1;
            end
         end
      end
   end

   mem_lat_legal: assert property (@(posedge iCLK) (MEM_LAT >= 1) && (MEM_LAT <= 3));

endmodule
